// File: rtl/life_datapath_grid.sv
// Game-of-Life datapath: ROWS x COLS cell register with two-button serial programming,
// single-cycle generation step, optional toroidal wrap, saturating generation counter and halt-on-stable.
module life_datapath_grid #(
  parameter int ROWS      = 7,
  parameter int COLS      = 7,
  parameter int WRAP      = 0,
  parameter int GEN_W     = 16,
  parameter int AUTO_HALT = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      state,
  input  logic                            btn0,
  input  logic                            btn1,
  input  logic                            stop,
  input  logic                            tick,
  output logic [ROWS*COLS-1:0]            grid,
  output logic [$clog2(ROWS*COLS)-1:0]    cursor,
  output logic                            prog_done,
  output logic [GEN_W-1:0]                gen_count,
  output logic                            stable,
  output logic                            extinct
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CELL = CW'(N - 1);

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'b00,
    MODE_PROGRAM = 2'b01,
    MODE_RUN     = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  mode_e         mode;
  logic          btn0_q;
  logic          btn1_q;
  logic          edge0;
  logic          edge1;
  logic          halted;
  logic [N-1:0]  next_grid;

  assign mode    = mode_e'(state);
  assign edge0   = btn0 & ~btn0_q;
  assign edge1   = btn1 & ~btn1_q;
  assign halted  = (AUTO_HALT != 0) && stable;
  assign extinct = ~|grid;

  // Next generation for every cell at once; the loops unroll into one adder tree per cell.
  // NOTE: every variable written here gets a value before any conditional path, so no latch is inferred.
  always_comb begin
    int       rr;
    int       cc;
    logic [3:0] nbr;
    next_grid = '0;
    nbr       = '0;
    rr        = 0;
    cc        = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        nbr = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
              rr = r + dr;
              cc = c + dc;
              if (WRAP != 0) begin
                rr = (rr + ROWS) % ROWS;
                cc = (cc + COLS) % COLS;
              end
              if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                nbr = nbr + {3'b000, grid[CW'(rr * COLS + cc)]};
              end
            end
          end
        end
        next_grid[CW'(r * COLS + c)] = (nbr == 4'd3) |
                                       (grid[CW'(r * COLS + c)] & (nbr == 4'd2));
      end
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid      <= '0;
      cursor    <= '0;
      prog_done <= 1'b0;
      gen_count <= '0;
      stable    <= 1'b0;
      btn0_q    <= 1'b0;
      btn1_q    <= 1'b0;
    end else begin
      // Edge history tracks the buttons in every mode so a held button never writes on mode entry.
      btn0_q    <= btn0;
      btn1_q    <= btn1;
      prog_done <= 1'b0;
      if (stop) begin
        grid      <= '0;
        cursor    <= '0;
        gen_count <= '0;
        stable    <= 1'b0;
      end else begin
        case (mode)
          MODE_IDLE: begin
            cursor <= '0;
          end
          MODE_PROGRAM: begin
            stable <= 1'b0;
            if (edge0 ^ edge1) begin
              grid[cursor] <= edge1;
              if (cursor == LAST_CELL) begin
                cursor    <= '0;
                prog_done <= 1'b1;
              end else begin
                cursor <= cursor + 1'b1;
              end
            end
          end
          MODE_RUN: begin
            if (tick && !halted) begin
              grid   <= next_grid;
              stable <= (next_grid == grid);
              if (gen_count != '1) begin
                gen_count <= gen_count + 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_life_datapath_grid.sv
// Self-checking bench: three grid configurations share one stimulus stream and are compared
// each cycle against a behavioural Game-of-Life model, plus directed boundary scenarios.
module tb_life_datapath_grid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  state = 2'b00;
  logic        btn0 = 1'b0;
  logic        btn1 = 1'b0;
  logic        stop = 1'b0;
  logic        tick = 1'b0;

  logic [48:0] grid_a;
  logic [5:0]  cursor_a;
  logic        pd_a, st_a, ex_a;
  logic [15:0] gen_a;
  logic [24:0] grid_b, grid_c;
  logic [4:0]  cursor_b, cursor_c;
  logic        pd_b, st_b, ex_b, pd_c, st_c, ex_c;
  logic [15:0] gen_b, gen_c;

  always #5 clk = ~clk;

  life_datapath_grid #(.ROWS(7), .COLS(7), .WRAP(0), .GEN_W(16), .AUTO_HALT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .state(state), .btn0(btn0), .btn1(btn1), .stop(stop), .tick(tick),
    .grid(grid_a), .cursor(cursor_a), .prog_done(pd_a), .gen_count(gen_a), .stable(st_a), .extinct(ex_a));

  life_datapath_grid #(.ROWS(5), .COLS(5), .WRAP(0), .GEN_W(16), .AUTO_HALT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .state(state), .btn0(btn0), .btn1(btn1), .stop(stop), .tick(tick),
    .grid(grid_b), .cursor(cursor_b), .prog_done(pd_b), .gen_count(gen_b), .stable(st_b), .extinct(ex_b));

  life_datapath_grid #(.ROWS(5), .COLS(5), .WRAP(1), .GEN_W(16), .AUTO_HALT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .state(state), .btn0(btn0), .btn1(btn1), .stop(stop), .tick(tick),
    .grid(grid_c), .cursor(cursor_c), .prog_done(pd_c), .gen_count(gen_c), .stable(st_c), .extinct(ex_c));

  typedef struct {
    logic [63:0] grid;
    int          cursor;
    int          gen;
    bit          stable;
    bit          prog_done;
    bit          b0q;
    bit          b1q;
  } model_t;

  model_t m [3];
  int rows [3] = '{7, 5, 5};
  int cols [3] = '{7, 5, 5};
  int wrap [3] = '{0, 0, 1};
  int ah   [3] = '{1, 0, 1};

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Conway rule applied cell by cell: count live neighbours, then decide survival/birth.
  function automatic logic [63:0] life_step(input logic [63:0] g, input int nr, input int nc, input int wr);
    logic [63:0] res;
    res = '0;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        int live;
        live = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (wr != 0) begin
              rr = (rr + nr) % nr;
              cc = (cc + nc) % nc;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < nr && cc >= 0 && cc < nc)
              live += int'(g[rr * nc + cc]);
          end
        end
        res[r * nc + c] = (live == 3) || (g[r * nc + c] && live == 2);
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m[k] = '{grid: '0, cursor: 0, gen: 0, stable: 0, prog_done: 0, b0q: 0, b1q: 0};
    end
  endtask

  task automatic model_step(input int k);
    int          n;
    bit          e0, e1;
    logic [63:0] nxt;
    n  = rows[k] * cols[k];
    e0 = btn0 && !m[k].b0q;
    e1 = btn1 && !m[k].b1q;
    m[k].b0q = btn0;
    m[k].b1q = btn1;
    m[k].prog_done = 0;
    if (stop) begin
      m[k].grid = '0;
      m[k].cursor = 0;
      m[k].gen = 0;
      m[k].stable = 0;
    end else begin
      case (state)
        2'b00: m[k].cursor = 0;
        2'b01: begin
          m[k].stable = 0;
          if (e0 != e1) begin
            m[k].grid[m[k].cursor] = e1;
            if (m[k].cursor == n - 1) begin
              m[k].cursor = 0;
              m[k].prog_done = 1;
            end else begin
              m[k].cursor++;
            end
          end
        end
        2'b10: begin
          if (tick && !(ah[k] != 0 && m[k].stable)) begin
            nxt = life_step(m[k].grid, rows[k], cols[k], wrap[k]);
            m[k].stable = (nxt == m[k].grid);
            m[k].grid = nxt;
            if (m[k].gen < 65535) m[k].gen++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    check("a_grid",    64'(grid_a),   m[0].grid);
    check("a_cursor",  64'(cursor_a), 64'(m[0].cursor));
    check("a_pdone",   64'(pd_a),     64'(m[0].prog_done));
    check("a_gen",     64'(gen_a),    64'(m[0].gen));
    check("a_stable",  64'(st_a),     64'(m[0].stable));
    check("a_extinct", 64'(ex_a),     64'(m[0].grid == 0));
    check("b_grid",    64'(grid_b),   m[1].grid);
    check("b_cursor",  64'(cursor_b), 64'(m[1].cursor));
    check("b_pdone",   64'(pd_b),     64'(m[1].prog_done));
    check("b_gen",     64'(gen_b),    64'(m[1].gen));
    check("b_stable",  64'(st_b),     64'(m[1].stable));
    check("b_extinct", 64'(ex_b),     64'(m[1].grid == 0));
    check("c_grid",    64'(grid_c),   m[2].grid);
    check("c_cursor",  64'(cursor_c), 64'(m[2].cursor));
    check("c_pdone",   64'(pd_c),     64'(m[2].prog_done));
    check("c_gen",     64'(gen_c),    64'(m[2].gen));
    check("c_stable",  64'(st_c),     64'(m[2].stable));
    check("c_extinct", 64'(ex_c),     64'(m[2].grid == 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    compare();
  endtask

  task automatic press(input bit one);
    if (one) btn1 = 1'b1;
    else     btn0 = 1'b1;
    cycle();
    btn0 = 1'b0;
    btn1 = 1'b0;
    cycle();
  endtask

  task automatic clear_and_program();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    state = 2'b01;
    cycle();
  endtask

  initial begin
    model_reset();
    #1;
    compare();
    #11 rst_n = 1'b1;
    cycle();

    // 7x7 horizontal blinker at row 3
    clear_and_program();
    repeat (23) press(1'b0);
    repeat (3)  press(1'b1);
    check("t2_grid",   64'(grid_a),   64'h0000_0000_0380_0000);
    check("t2_cursor", 64'(cursor_a), 64'd26);

    state = 2'b10;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    check("t3_vert", 64'(grid_a), 64'h0000_0000_8102_0000);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
    check("t3_horiz",  64'(grid_a), 64'h0000_0000_0380_0000);
    check("t3_gen",    64'(gen_a),  64'd2);
    check("t3_stable", 64'(st_a),   64'd0);

    // Asynchronous reset mid-RUN takes effect without a clock edge
    tick = 1'b1;
    cycle();
    #2 rst_n = 1'b0;
    tick = 1'b0;
    #1;
    model_reset();
    check("t1_grid",   64'(grid_a),   64'd0);
    check("t1_cursor", 64'(cursor_a), 64'd0);
    check("t1_gen",    64'(gen_a),    64'd0);
    check("t1_stable", 64'(st_a),     64'd0);
    compare();
    #1 rst_n = 1'b1;
    cycle();

    // 2x2 block is a still life: one tick sets stable, later ticks are ignored
    clear_and_program();
    press(1'b1); press(1'b1);
    repeat (5) press(1'b0);
    press(1'b1); press(1'b1);
    state = 2'b10;
    tick = 1'b1;
    cycle();
    check("t4_grid",   64'(grid_a), 64'h183);
    check("t4_stable", 64'(st_a),   64'd1);
    check("t4_gen1",   64'(gen_a),  64'd1);
    repeat (3) cycle();
    tick = 1'b0;
    check("t4_gen_frozen", 64'(gen_a), 64'd1);

    // 5x5 vertical blinker on the left edge, with and without wrap
    clear_and_program();
    repeat (5) press(1'b0);
    press(1'b1);
    repeat (4) press(1'b0);
    press(1'b1);
    repeat (4) press(1'b0);
    press(1'b1);
    check("t5_prog", 64'(grid_b), 64'h8420);
    state = 2'b10;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    check("t5_nowrap", 64'(grid_b), 64'hC00);
    check("t5_wrap",   64'(grid_c), 64'h4C00);

    // Simultaneous button edges, cursor wrap pulse, stop in RUN
    clear_and_program();
    btn0 = 1'b1;
    btn1 = 1'b1;
    cycle();
    check("t6_both_cursor", 64'(cursor_a), 64'd0);
    check("t6_both_grid",   64'(grid_a),   64'd0);
    btn0 = 1'b0;
    btn1 = 1'b0;
    cycle();
    repeat (48) press(1'b0);
    btn0 = 1'b1;
    cycle();
    check("t6_pdone_hi",  64'(pd_a),     64'd1);
    check("t6_cursor_wr", 64'(cursor_a), 64'd0);
    btn0 = 1'b0;
    cycle();
    check("t6_pdone_lo", 64'(pd_a), 64'd0);
    press(1'b1);
    state = 2'b10;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    check("t6_gen_pre", 64'(gen_a), 64'd1);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("t6_stop_grid", 64'(grid_a), 64'd0);
    check("t6_stop_gen",  64'(gen_a),  64'd0);

    // Randomised mix of modes, buttons, ticks and occasional stop
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom % 8);
      if (r < 3)      state = 2'b01;
      else if (r < 6) state = 2'b10;
      else if (r < 7) state = 2'b11;
      else            state = 2'b00;
      btn0 = ($urandom % 3) == 0;
      btn1 = ($urandom % 3) == 0;
      tick = ($urandom % 2) == 0;
      stop = ($urandom % 50) == 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
